// File: rtl/multiply_divide_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package multiply_divide_unit_pkg;

  // Operation select carried on ctrl. Code 7 is undefined and behaves like MDU_NONE.
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int CNT_W = 5;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic is_multi_cycle(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // True for the divide family (selects the divide latency).
  function automatic logic is_divide(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational datapath: produces the 64-bit {hi, lo} result for one
// multiply or divide, including divide-by-zero and signed-overflow results.
module mdu_compute
  import multiply_divide_unit_pkg::*;
(
  input  logic    [31:0] i_a,
  input  logic    [31:0] i_b,
  input  mdu_op_e        i_op,
  output logic    [63:0] o_result
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic        w_b_zero;
  logic        w_div_ovf;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_divisor;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_q;
  logic [31:0] w_r;

  // Both products are formed at 64 bits so the full result is kept.
  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // A single unsigned divider serves both DIV and DIVU: signed division runs on
  // magnitudes and the signs are restored afterwards (quotient truncates toward
  // zero, remainder follows the dividend).
  assign w_signed_div = (i_op == MDU_DIV);
  assign w_b_zero     = (i_b == 32'd0);
  assign w_div_ovf    = w_signed_div && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  assign w_mag_a      = (w_signed_div && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign w_mag_b      = (w_signed_div && i_b[31]) ? (~i_b + 32'd1) : i_b;
  // Keep the divider away from a zero divisor; that case is overridden below.
  assign w_divisor    = w_b_zero ? 32'd1 : w_mag_b;
  assign w_quot       = w_mag_a / w_divisor;
  assign w_rem        = w_mag_a % w_divisor;
  assign w_q          = (w_signed_div && (i_a[31] ^ i_b[31])) ? (~w_quot + 32'd1) : w_quot;
  assign w_r          = (w_signed_div && i_a[31]) ? (~w_rem + 32'd1) : w_rem;

  // Result select per operation, with the divide special cases taking priority.
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives o_result, so no latch is inferred.
    o_result = '0;
    case (i_op)
      MDU_MULT:  o_result = w_prod_s;
      MDU_MULTU: o_result = w_prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (w_b_zero) begin
          o_result = {i_a, 32'hFFFF_FFFF};
        end else if (w_div_ovf) begin
          o_result = {32'd0, 32'h8000_0000};
        end else begin
          o_result = {w_r, w_q};
        end
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/multiply_divide_unit.sv
// Multi-cycle HI/LO unit: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO while idle,
// holds busy for the configured latency and commits HI/LO atomically.
module multiply_divide_unit
  import multiply_divide_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,   // legal range 1..31
  parameter int DIV_CYCLES  = 10   // legal range 1..31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ctrl,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e       r_state;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_pending;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  mdu_op_e          w_op;
  logic [63:0]      w_result;

  assign w_op = mdu_op_e'(ctrl);

  mdu_compute u_compute (
    .i_a      (A),
    .i_b      (B),
    .i_op     (w_op),
    .o_result (w_result)
  );

  // Control FSM: accept in IDLE, count down in RUN, commit HI/LO on the last edge.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_pending <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (is_multi_cycle(w_op)) begin
              // Operands are consumed here; later changes on A/B are irrelevant.
              r_pending <= w_result;
              r_count   <= is_divide(w_op) ? DIV_LOAD : MULT_LOAD;
              r_busy    <= 1'b1;
              r_state   <= ST_RUN;
            end else if (w_op == MDU_MTHI) begin
              r_hi <= A;
            end else if (w_op == MDU_MTLO) begin
              r_lo <= A;
            end
          end
        end
        ST_RUN: begin
          // start is deliberately not examined here: requests while busy are dropped.
          if (r_count == '0) begin
            r_hi    <= r_pending[63:32];
            r_lo    <= r_pending[31:0];
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Self-checking bench for multiply_divide_unit: directed cases plus randomized
// operations compared against an arithmetic reference model of HI/LO.
module tb_multiply_divide_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  ctrl = OP_NONE;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model of the architectural registers.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  multiply_divide_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .ctrl  (ctrl),
    .start (start),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int exp_latency(input logic [2:0] op);
    if (op == OP_MULT || op == OP_MULTU) return MULT_N;
    if (op == OP_DIV || op == OP_DIVU) return DIV_N;
    return 0;
  endfunction

  // Architectural effect of one accepted operation, from plain integer arithmetic.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int                sa;
    int                sb;
    longint            sp;
    longint unsigned   up;
    sa = a;
    sb = b;
    case (op)
      OP_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {exp_hi, exp_lo} = sp;
      end
      OP_MULTU: begin
        up = a;
        up = up * b;
        {exp_hi, exp_lo} = up;
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          exp_hi = a; exp_lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          exp_hi = 32'd0; exp_lo = 32'h8000_0000;
        end else begin
          exp_lo = sa / sb;
          exp_hi = sa % sb;
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          exp_hi = a; exp_lo = 32'hFFFF_FFFF;
        end else begin
          exp_lo = a / b;
          exp_hi = a % b;
        end
      end
      OP_MTHI: exp_hi = a;
      OP_MTLO: exp_lo = a;
      default: ;
    endcase
  endtask

  // Drives one start pulse from the current negedge, scrambles the operands
  // afterwards, then counts busy cycles and notes whether hi/lo moved early.
  // Returns at the first negedge with busy low.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles, output bit held);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = hi;
    l0 = lo;
    ctrl = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ctrl = OP_NONE; A = $urandom; B = $urandom;
    cycles = 0;
    held = 1'b1;
    while (busy === 1'b1 && cycles < 100) begin
      if (hi !== h0 || lo !== l0) held = 1'b0;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ctrl = OP_NONE; A = '0; B = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", hi); end
    tests_run++;
    if (lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", lo); end
  endtask

  task automatic test_mult();
    int cyc;
    bit held;
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, cyc, held);
    model_apply(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    tests_run++;
    if (cyc !== MULT_N) begin tests_failed++; $display("FAIL mult_latency: got %0d expected %0d", cyc, MULT_N); end
    tests_run++;
    if (held !== 1'b1) begin tests_failed++; $display("FAIL mult_hold: hi/lo changed while busy, expected stable"); end
    tests_run++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      tests_failed++; $display("FAIL mult_result: got %h_%h expected FFFFFFFF_FFFFFFFA", hi, lo);
    end
    do_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, cyc, held);
    model_apply(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    tests_run++;
    if (cyc !== MULT_N) begin tests_failed++; $display("FAIL multu_latency: got %0d expected %0d", cyc, MULT_N); end
    tests_run++;
    if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      tests_failed++; $display("FAIL multu_result: got %h_%h expected 00000002_FFFFFFFA", hi, lo);
    end
  endtask

  // DIV followed immediately by DIVU in the first idle cycle.
  task automatic test_back_to_back();
    int cyc;
    bit held;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc, held);
    model_apply(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    tests_run++;
    if (cyc !== DIV_N) begin tests_failed++; $display("FAIL div_latency: got %0d expected %0d", cyc, DIV_N); end
    tests_run++;
    if (held !== 1'b1) begin tests_failed++; $display("FAIL div_hold: hi/lo changed while busy, expected stable"); end
    tests_run++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      tests_failed++; $display("FAIL div_result: got %h_%h expected FFFFFFFF_FFFFFFFD", hi, lo);
    end
    do_op(OP_DIVU, 32'd7, 32'd2, cyc, held);
    model_apply(OP_DIVU, 32'd7, 32'd2);
    tests_run++;
    if (cyc !== DIV_N) begin tests_failed++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, DIV_N); end
    tests_run++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      tests_failed++; $display("FAIL b2b_result: got %h_%h expected 00000001_00000003", hi, lo);
    end
  endtask

  task automatic test_div_boundary();
    int cyc;
    bit held;
    do_op(OP_DIVU, 32'h1234_5678, 32'd0, cyc, held);
    model_apply(OP_DIVU, 32'h1234_5678, 32'd0);
    tests_run++;
    if (cyc !== DIV_N) begin tests_failed++; $display("FAIL divzero_latency: got %0d expected %0d", cyc, DIV_N); end
    tests_run++;
    if (hi !== 32'h1234_5678 || lo !== 32'hFFFF_FFFF) begin
      tests_failed++; $display("FAIL divzero_result: got %h_%h expected 12345678_FFFFFFFF", hi, lo);
    end
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held);
    model_apply(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      tests_failed++; $display("FAIL divovf_result: got %h_%h expected 00000000_80000000", hi, lo);
    end
  endtask

  // MTHI is single-cycle; MTLO and a second MULT issued while busy are dropped.
  task automatic test_ignore_while_busy();
    int          cyc;
    bit          held;
    bit          late_busy;
    logic [31:0] a1;
    logic [31:0] b1;
    do_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, cyc, held);
    model_apply(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    tests_run++;
    if (cyc !== 0) begin tests_failed++; $display("FAIL mthi_busy: got %0d busy cycles expected 0", cyc); end
    tests_run++;
    if (hi !== 32'hDEAD_BEEF || lo !== exp_lo) begin
      tests_failed++; $display("FAIL mthi_result: got %h_%h expected DEADBEEF_%h", hi, lo, exp_lo);
    end
    a1 = $urandom; b1 = $urandom;
    ctrl = OP_MULT; A = a1; B = b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ctrl = OP_NONE;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == 2) begin
        ctrl = OP_MTLO; A = 32'hA5A5_5A5A; start = 1'b1;
      end else if (cyc == 4) begin
        ctrl = OP_MULT; A = $urandom; B = $urandom; start = 1'b1;
      end else begin
        ctrl = OP_NONE; start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; ctrl = OP_NONE;
    model_apply(OP_MULT, a1, b1);
    tests_run++;
    if (cyc !== MULT_N) begin tests_failed++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, MULT_N); end
    tests_run++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      tests_failed++; $display("FAIL ignore_result: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo);
    end
    late_busy = 1'b0;
    repeat (3) begin
      if (busy !== 1'b0) late_busy = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (late_busy !== 1'b0) begin tests_failed++; $display("FAIL ignore_queued: got busy after commit, expected idle"); end
  endtask

  // Reset during busy cycle 4 of a DIV aborts it with no later commit.
  task automatic test_reset_abort();
    int cyc;
    bit held;
    bit saw_busy;
    bit saw_change;
    do_op(OP_MTHI, 32'h1111_1111, 32'd0, cyc, held);
    do_op(OP_MTLO, 32'h2222_2222, 32'd0, cyc, held);
    tests_run++;
    if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      tests_failed++; $display("FAIL preload: got %h_%h expected 11111111_22222222", hi, lo);
    end
    ctrl = OP_DIV; A = 32'd100; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ctrl = OP_NONE;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL abort_precond: got busy %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++; $display("FAIL abort_reset: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    saw_busy = 1'b0;
    saw_change = 1'b0;
    repeat (DIV_N + 5) begin
      @(negedge clk);
      if (busy !== 1'b0) saw_busy = 1'b1;
      if (hi !== 32'd0 || lo !== 32'd0) saw_change = 1'b1;
    end
    tests_run++;
    if (saw_busy !== 1'b0 || saw_change !== 1'b0) begin
      tests_failed++; $display("FAIL abort_commit: got busy=%b change=%b expected none", saw_busy, saw_change);
    end
  endtask

  task automatic test_random();
    int          cyc;
    bit          held;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      do_op(op, a, b, cyc, held);
      model_apply(op, a, b);
      tests_run++;
      if (cyc !== exp_latency(op)) begin
        tests_failed++; $display("FAIL rand_latency[%0d] op=%0d: got %0d expected %0d", i, op, cyc, exp_latency(op));
      end
      tests_run++;
      if (held !== 1'b1) begin
        tests_failed++; $display("FAIL rand_hold[%0d] op=%0d: hi/lo changed while busy, expected stable", i, op);
      end
      tests_run++;
      if (hi !== exp_hi || lo !== exp_lo) begin
        tests_failed++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, op, a, b, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_boundary();
    test_ignore_while_busy();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multiply_divide_unit.md
Name: multiply_divide_unit

Overview:
- Multi-cycle HI/LO arithmetic unit in the execute stage, beside the single-cycle ALU. It executes the operations the ALU does not: MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- It owns the architectural HI/LO registers and raises busy while an operation is in flight.
- The hazard unit stalls on busy and on any HI/LO access issued while busy.

Parameters:
- MULT_CYCLES, 5, cycles from accepted start to HI/LO commit for MULT/MULTU; legal range 1..31.
- DIV_CYCLES, 10, cycles from accepted start to HI/LO commit for DIV/DIVU; legal range 1..31.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  32  operand A (rs value).
- B  input  32  operand B (rt value).
- ctrl  input  3  operation select, `mdu* constants.
- start  input  1  qualifies ctrl/A/B for one cycle.
- busy  output  1  high while a MULT/DIV is in flight.
- hi  output  32  committed HI register.
- lo  output  32  committed LO register.

Behaviour:
- Reset (synchronous, active-high):
  - hi=0, lo=0, busy=0, counter=0.
  - Any in-flight operation is aborted with no commit.
  - Reset has priority over start.
- Acceptance:
  - start is sampled at a rising edge only when busy=0 and reset=0.
  - start while busy=1 is ignored entirely: no state change, no queuing.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; holds the 5-bit down-counter and 64-bit pending result.
- IDLE -> RUN, on accepted start with ctrl in {mduMult, mduMultU, mduDiv, mduDivU}:
  - Latch the pending result computed from A/B at that edge.
  - Load counter = MULT_CYCLES-1 or DIV_CYCLES-1 as appropriate.
  - busy goes 1 after the edge.
- RUN:
  - Decrement the counter each cycle.
  - On the edge where the counter is 0, commit pending[63:32] -> hi and pending[31:0] -> lo, clear busy, and return to IDLE.
  - Net effect: busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - The new hi/lo are visible in the first cycle busy=0.
- hi/lo hold their old values throughout RUN and are never partially updated.
- Single-cycle ops, accepted in IDLE:
  - mduMTHI: hi<=A at that edge, lo unchanged, busy stays 0.
  - mduMTLO: lo<=A at that edge, hi unchanged, busy stays 0.
  - mduNone, or undefined codes 7: no effect.
- Arithmetic:
  - MULT: 64-bit signed product of $signed(A)*$signed(B).
  - MULTU: 64-bit unsigned product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (both DIV and DIVU): lo=32'hFFFFFFFF, hi=A, with full DIV latency.
  - DIV overflow, A=32'h80000000 with B=32'hFFFFFFFF: lo=32'h80000000, hi=0.
- Back-to-back: a new start is accepted in the first cycle busy=0, i.e. the cycle after commit.
- Operands are captured at acceptance. Later changes on A/B do not affect the result.

Decomposition:
- The following belong in constants.v beside the `alu* codes, as 3-bit `mdu* op codes:
  - mduNone=0, mduMult=1, mduMultU=2, mduDiv=3, mduDivU=4, mduMTHI=5, mduMTLO=6.
- One natural sub-module: mdu_compute.
  - Combinational; inputs A, B, op; output the 64-bit {hi,lo} result, including the divide-by-zero and overflow rules.
  - The top level holds only control, counter and registers.

Test Plan:
- MULT with A=32'hFFFFFFFE, B=3, start 1 cycle -> busy high exactly 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; hi/lo unchanged (0) while busy.
- MULTU with the same operands -> hi=32'h00000002, lo=32'hFFFFFFFA after 5 cycles.
- DIV A=32'hFFFFFFF9 (-7), B=2 -> after 10 cycles lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Then DIVU A=7, B=2 started the first idle cycle -> lo=3, hi=1.
- DIVU A=32'h12345678, B=0 -> lo=32'hFFFFFFFF, hi=32'h12345678. DIV A=32'h80000000, B=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- MTHI A=32'hDEADBEEF -> hi updates next edge, busy never rises. Then MULT starts, MTLO and a second MULT are pulsed while busy -> both ignored, lo reflects only the first MULT.
- Preload via MTHI/MTLO, start DIV, assert reset at busy cycle 4 -> next cycle busy=0, hi=lo=0, and no commit occurs later.
